// File: rtl/pci_arbiter_if.sv
// Bus-side signal bundle between the PCI arbiter and the device/bus wiring.
// The master modport is the arbiter's view; slave is the bus/device view.
interface pci_arbiter_if #(
  parameter int N_DEV = 4
);
  localparam int IDXW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  logic [N_DEV-1:0] REQ;
  logic             FRAME;
  logic             IRDY;
  logic [N_DEV-1:0] GNT;
  logic [IDXW-1:0]  OWNER;
  logic             BUS_BUSY;
  logic             TIMEOUT_ERR;

  modport master (
    input  REQ, FRAME, IRDY,
    output GNT, OWNER, BUS_BUSY, TIMEOUT_ERR
  );

  modport slave (
    output REQ, FRAME, IRDY,
    input  GNT, OWNER, BUS_BUSY, TIMEOUT_ERR
  );
endinterface

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grant of active-low REQ lines, bus-idle
// tracking from FRAME/IRDY, and revocation of grants that are never used.
module pci_arbiter #(
  parameter int N_DEV   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  pci_arbiter_if.master bus
);
  localparam int IDXW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANTED = 2'd1;
  localparam logic [1:0] S_BUSY    = 2'd2;
  localparam logic [1:0] S_TURN    = 2'd3;

  logic [1:0]       state;
  logic [N_DEV-1:0] gnt;
  logic [IDXW-1:0]  owner;
  logic [CW-1:0]    wait_cnt;
  logic             timeout_err;

  logic             bus_idle;
  logic             any_req;
  logic             others_req;
  logic [IDXW-1:0]  winner;
  logic [N_DEV-1:0] owner_mask;

  assign bus_idle   = bus.FRAME & bus.IRDY;
  assign owner_mask = N_DEV'(1) << owner;
  assign others_req = |(~bus.REQ & ~owner_mask);

  // Scan from owner+1 upward with wrap; the current owner is visited last.
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    winner  = owner;
    for (int i = 1; i <= N_DEV; i++) begin
      idx = (int'(owner) + i) % N_DEV;
      if (!any_req && !bus.REQ[idx]) begin
        any_req = 1'b1;
        winner  = IDXW'(idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      gnt         <= '1;
      owner       <= IDXW'(N_DEV - 1);
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req && bus_idle) begin
            gnt      <= ~(N_DEV'(1) << winner);
            owner    <= winner;
            wait_cnt <= '0;
            state    <= S_GRANTED;
          end else begin
            gnt <= '1;
          end
        end
        // FRAME wins over withdrawal and timeout: the owner has already started.
        S_GRANTED: begin
          if (!bus.FRAME) begin
            state <= S_BUSY;
          end else if (bus.REQ[owner]) begin
            gnt   <= '1;
            state <= S_IDLE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            gnt         <= '1;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        // Dropping GNT here only tells the owner to finish; nobody else is granted.
        S_BUSY: begin
          if (bus_idle) begin
            gnt   <= '1;
            state <= S_TURN;
          end else if (others_req) begin
            gnt <= '1;
          end
        end
        S_TURN: begin
          gnt   <= '1;
          state <= S_IDLE;
        end
        default: begin
          gnt   <= '1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.GNT         = gnt;
  assign bus.OWNER       = owner;
  assign bus.BUS_BUSY    = (state == S_BUSY);
  assign bus.TIMEOUT_ERR = timeout_err;
endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter (N_DEV=4, TIMEOUT=16) with hand-computed
// expectations for grant order, bus tracking, timeout and reset behaviour.
module tb_pci_arbiter;
  logic CLK;
  logic RST;
  int   errors;
  int   checks;

  pci_arbiter_if #(.N_DEV(4)) bus ();

  pci_arbiter #(.N_DEV(4), .TIMEOUT(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // No more than one grant may ever be low outside reset.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      checks++;
      if ($countones(~bus.GNT) > 1) begin
        errors++;
        $display("[TB] FAIL onehot_gnt: got GNT=%b want at most one low bit", bus.GNT);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST       = 1'b0;
    bus.REQ   = 4'b1111;
    bus.FRAME = 1'b1;
    bus.IRDY  = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.GNT !== 4'b1111) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 1111", bus.GNT); end
    checks++;
    if (bus.OWNER !== 2'd3) begin errors++; $display("[TB] FAIL reset_owner: got %0d want 3", bus.OWNER); end
    checks++;
    if (bus.BUS_BUSY !== 1'b0 || bus.TIMEOUT_ERR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy=%b terr=%b want 0 0", bus.BUS_BUSY, bus.TIMEOUT_ERR);
    end
    RST = 1'b1;
  endtask

  task automatic test_grant();
    bus.REQ = 4'b1110;
    tick();
    checks++;
    if (bus.GNT !== 4'b1110) begin errors++; $display("[TB] FAIL grant_gnt: got %b want 1110", bus.GNT); end
    checks++;
    if (bus.OWNER !== 2'd0) begin errors++; $display("[TB] FAIL grant_owner: got %0d want 0", bus.OWNER); end
    tick();
    checks++;
    if (bus.GNT !== 4'b1110 || bus.BUS_BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL grant_hold: got GNT=%b busy=%b want 1110 0", bus.GNT, bus.BUS_BUSY);
    end
  endtask

  task automatic test_transfer();
    bus.FRAME = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.BUS_BUSY !== 1'b1 || bus.GNT !== 4'b1110) begin
        errors++;
        $display("[TB] FAIL xfer_busy%0d: got busy=%b GNT=%b want 1 1110", i, bus.BUS_BUSY, bus.GNT);
      end
    end
    bus.FRAME = 1'b1;
    bus.IRDY  = 1'b1;
    bus.REQ   = 4'b1111;
    tick();
    checks++;
    if (bus.GNT !== 4'b1111 || bus.BUS_BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL xfer_turn: got GNT=%b busy=%b want 1111 0", bus.GNT, bus.BUS_BUSY);
    end
    tick();
    tick();
    checks++;
    if (bus.GNT !== 4'b1111 || bus.BUS_BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL xfer_idle: got GNT=%b busy=%b want 1111 0", bus.GNT, bus.BUS_BUSY);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] one;
    logic [3:0] want;
    int         exp;
    one = 4'b0001;
    bus.REQ = 4'b1111;
    do_reset();
    bus.REQ = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      exp  = k % 4;
      want = ~(one << exp);
      tick();
      checks++;
      if (bus.GNT !== want || bus.OWNER !== 2'(exp)) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d: got GNT=%b owner=%0d want %b %0d", k, bus.GNT, bus.OWNER, want, exp);
      end
      bus.FRAME = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.GNT !== 4'b1111 || bus.BUS_BUSY !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_preempt%0d: got GNT=%b busy=%b want 1111 1", k, bus.GNT, bus.BUS_BUSY);
      end
      bus.FRAME = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.GNT !== 4'b1111) begin
        errors++;
        $display("[TB] FAIL rr_gap%0d: got GNT=%b want 1111", k, bus.GNT);
      end
    end
    bus.REQ = 4'b1111;
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    bus.REQ = 4'b1111;
    do_reset();
    bus.REQ = 4'b1101;
    tick();
    checks++;
    if (bus.GNT !== 4'b1101) begin errors++; $display("[TB] FAIL to_grant: got %b want 1101", bus.GNT); end
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.GNT !== 4'b1101 || bus.TIMEOUT_ERR !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL to_hold16: got GNT=%b terr=%b want 1101 0 for 16 cycles", bus.GNT, bus.TIMEOUT_ERR);
    end
    tick();
    checks++;
    if (bus.GNT !== 4'b1111 || bus.TIMEOUT_ERR !== 1'b1 || bus.OWNER !== 2'd1) begin
      errors++;
      $display("[TB] FAIL to_revoke: got GNT=%b terr=%b owner=%0d want 1111 1 1", bus.GNT, bus.TIMEOUT_ERR, bus.OWNER);
    end
    tick();
    checks++;
    if (bus.GNT !== 4'b1101 || bus.TIMEOUT_ERR !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_regrant: got GNT=%b terr=%b want 1101 0", bus.GNT, bus.TIMEOUT_ERR);
    end
    bus.REQ = 4'b1111;
    tick();
    checks++;
    if (bus.GNT !== 4'b1111) begin errors++; $display("[TB] FAIL to_withdraw: got %b want 1111", bus.GNT); end
  endtask

  task automatic test_preempt();
    bus.REQ = 4'b1111;
    do_reset();
    bus.REQ = 4'b1110;
    tick();
    bus.FRAME = 1'b0;
    tick();
    bus.REQ = 4'b1010;
    tick();
    checks++;
    if (bus.GNT !== 4'b1111 || bus.BUS_BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_drop: got GNT=%b busy=%b want 1111 1", bus.GNT, bus.BUS_BUSY);
    end
    tick();
    checks++;
    if (bus.GNT !== 4'b1111) begin errors++; $display("[TB] FAIL pre_nogrant: got %b want 1111", bus.GNT); end
    bus.FRAME = 1'b1;
    tick();
    checks++;
    if (bus.GNT !== 4'b1111 || bus.BUS_BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pre_turn: got GNT=%b busy=%b want 1111 0", bus.GNT, bus.BUS_BUSY);
    end
    tick();
    tick();
    checks++;
    if (bus.GNT !== 4'b1011 || bus.OWNER !== 2'd2) begin
      errors++;
      $display("[TB] FAIL pre_next: got GNT=%b owner=%0d want 1011 2", bus.GNT, bus.OWNER);
    end
    bus.REQ = 4'b1111;
    tick();
  endtask

  task automatic test_foreign_cycle();
    bus.REQ  = 4'b1111;
    do_reset();
    bus.IRDY = 1'b0;
    bus.REQ  = 4'b1110;
    tick();
    tick();
    checks++;
    if (bus.GNT !== 4'b1111) begin errors++; $display("[TB] FAIL foreign_hold: got %b want 1111", bus.GNT); end
    bus.IRDY = 1'b1;
    tick();
    checks++;
    if (bus.GNT !== 4'b1110) begin errors++; $display("[TB] FAIL foreign_grant: got %b want 1110", bus.GNT); end
    bus.REQ = 4'b1111;
    tick();
  endtask

  task automatic test_precedence_and_reset();
    bus.REQ = 4'b1111;
    do_reset();
    bus.REQ = 4'b1101;
    tick();
    bus.FRAME = 1'b0;
    bus.REQ   = 4'b1111;
    tick();
    checks++;
    if (bus.BUS_BUSY !== 1'b1 || bus.GNT !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL prec_busy: got busy=%b GNT=%b want 1 1101", bus.BUS_BUSY, bus.GNT);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (bus.GNT !== 4'b1111 || bus.BUS_BUSY !== 1'b0 || bus.OWNER !== 2'd3) begin
      errors++;
      $display("[TB] FAIL midreset: got GNT=%b busy=%b owner=%0d want 1111 0 3", bus.GNT, bus.BUS_BUSY, bus.OWNER);
    end
    RST       = 1'b1;
    bus.FRAME = 1'b1;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_grant();
    test_transfer();
    test_round_robin();
    test_timeout();
    test_preempt();
    test_foreign_cycle();
    test_precedence_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
